ret_addr_stack: RTL and testbench

- Return address stack (RAS) in the fetch stage; consumer of the pre-decoder's call/return flags.
- Pushes the link address (pc+4) on a call.
- On a return, pops and presents the predicted return target in the same cycle, so fetch can redirect.
- Speculative state is discarded on a backend flush; optional checkpoint/restore gives precise mispredict recovery.

---
 rtl/ret_addr_stack_pkg.sv | 20 ++
 rtl/ret_addr_stack_if.sv | 41 ++++
 rtl/ret_addr_stack.sv | 124 ++++++++++++
 tb/tb_ret_addr_stack.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ret_addr_stack_pkg.sv
// Shared fetch-stage definitions: opcode constants, RAS checkpoint record and link offset.
// The checkpoint record is used only when RAS_CHECKPOINT_EN is defined.
package ret_addr_stack_pkg;

    localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR = 7'b1100111;

    localparam int unsigned RAS_DEPTH    = 8;
    localparam int unsigned RAS_XLEN     = 32;
    localparam int unsigned RAS_PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_LINK_OFS = 4;

    // Sized for the widest supported stack; a smaller instance zero-extends into it.
    typedef struct packed {
        logic [RAS_PTR_W-1:0] ptr;
        logic [RAS_PTR_W:0]   cnt;
        logic [RAS_XLEN-1:0]  top;
    } ras_ckpt_t;

endpackage

// File: rtl/ret_addr_stack_if.sv
// Fetch <-> return-address-stack signal bundle; master = fetch/pre-decode, slave = RAS.
// Checkpoint signals exist only when RAS_CHECKPOINT_EN is defined.
interface ret_addr_stack_if #(
    parameter int unsigned XLEN = 32
) ();
    import ret_addr_stack_pkg::*;

    logic            instr_vld_i;
    logic            call_i;
    logic            return_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;
    logic            pred_vld_o;
    logic [XLEN-1:0] pred_target_o;
    logic            empty_o;
    logic            full_o;
`ifdef RAS_CHECKPOINT_EN
    ras_ckpt_t       ckpt_o;
    logic            restore_i;
    ras_ckpt_t       restore_ckpt_i;
`endif

    modport master (
        output instr_vld_i, call_i, return_i, pc_i, flush_i,
`ifdef RAS_CHECKPOINT_EN
        output restore_i, restore_ckpt_i,
        input  ckpt_o,
`endif
        input  pred_vld_o, pred_target_o, empty_o, full_o
    );

    modport slave (
        input  instr_vld_i, call_i, return_i, pc_i, flush_i,
`ifdef RAS_CHECKPOINT_EN
        input  restore_i, restore_ckpt_i,
        output ckpt_o,
`endif
        output pred_vld_o, pred_target_o, empty_o, full_o
    );

endinterface

// File: rtl/ret_addr_stack.sv
// Return address stack: pushes pc+4 on calls, predicts the return target in the same cycle.
// Define RAS_CHECKPOINT_EN to add checkpoint/restore ports for precise mispredict recovery.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ret_addr_stack_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  entries_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_s, pop_s, has_s, full_s;
    logic             we_s;
    logic [PTR_W-1:0] waddr_s;
    logic [XLEN-1:0]  wdata_s;
    logic [XLEN-1:0]  link_s;
    logic             hold_s;

    assign has_s  = (count_q != CNT_W'(0));
    assign full_s = (count_q == CNT_W'(DEPTH));
    assign link_s = bus.pc_i + XLEN'(RAS_LINK_OFS);

`ifdef RAS_CHECKPOINT_EN
    assign hold_s = bus.flush_i | bus.restore_i;
    assign bus.ckpt_o.ptr = RAS_PTR_W'(tos_q);
    assign bus.ckpt_o.cnt = (RAS_PTR_W + 1)'(count_q);
    assign bus.ckpt_o.top = RAS_XLEN'(entries_q[tos_q]);
`else
    assign hold_s = bus.flush_i;
`endif

    assign push_s = bus.instr_vld_i & bus.call_i   & ~hold_s;
    assign pop_s  = bus.instr_vld_i & bus.return_i & ~hold_s;

    // Zero-latency prediction from pre-update state, plus status decoded from the registered count.
    always_comb begin
        bus.pred_vld_o    = pop_s & has_s;
        bus.pred_target_o = '0;
        if (bus.pred_vld_o) begin
            bus.pred_target_o = entries_q[tos_q];
        end else begin
            bus.pred_target_o = '0;
        end
        bus.empty_o = ~has_s;
        bus.full_o  = full_s;
    end

    // Next pointer/count and the single write port; flush beats restore beats push/pop.
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        we_s    = 1'b0;
        waddr_s = tos_q;
        wdata_s = link_s;
        if (bus.flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end
`ifdef RAS_CHECKPOINT_EN
        else if (bus.restore_i) begin
            tos_d   = PTR_W'(bus.restore_ckpt_i.ptr);
            count_d = CNT_W'(bus.restore_ckpt_i.cnt);
            we_s    = 1'b1;
            waddr_s = PTR_W'(bus.restore_ckpt_i.ptr);
            wdata_s = XLEN'(bus.restore_ckpt_i.top);
        end
`endif
        else if (push_s && pop_s && has_s) begin
            // Coroutine swap: replace the top in place.
            we_s    = 1'b1;
            waddr_s = tos_q;
        end else if (push_s) begin
            // On overflow the pointer wraps onto the oldest entry.
            tos_d   = tos_q + PTR_W'(1);
            we_s    = 1'b1;
            waddr_s = tos_q + PTR_W'(1);
            if (full_s) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_s && has_s) begin
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end else begin
            tos_d   = tos_q;
            count_d = count_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    // Entry storage; entries are never cleared by pop or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (we_s) begin
            entries_q[waddr_s] <= wdata_s;
        end else begin
            entries_q[waddr_s] <= entries_q[waddr_s];
        end
    end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Scoreboard bench for ret_addr_stack (DEPTH=4): directed vectors queue expectations, a monitor checks them.
// Define RAS_CHECKPOINT_EN to also exercise checkpoint/restore.
module tb_ret_addr_stack;
    import ret_addr_stack_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk;
    logic rst_n;

    ret_addr_stack_if #(.XLEN(XLEN)) bus ();

    ret_addr_stack #(.DEPTH(4), .XLEN(XLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            pv;
        logic [XLEN-1:0] tgt;
        logic            e;
        logic            f;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input string what, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, what, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pred_vld",    XLEN'(bus.pred_vld_o), XLEN'(e.pv));
                chk(e.name, "pred_target", bus.pred_target_o,     e.tgt);
                chk(e.name, "empty",       XLEN'(bus.empty_o),    XLEN'(e.e));
                chk(e.name, "full",        XLEN'(bus.full_o),     XLEN'(e.f));
            end
        end
    end

    task automatic step(input string name, input logic v, input logic c, input logic r,
                        input logic [XLEN-1:0] pc, input logic fl,
                        input logic epv, input logic [XLEN-1:0] etgt, input logic ee, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        bus.instr_vld_i = v;
        bus.call_i      = c;
        bus.return_i    = r;
        bus.pc_i        = pc;
        bus.flush_i     = fl;
`ifdef RAS_CHECKPOINT_EN
        bus.restore_i   = 1'b0;
`endif
        e.name = name; e.pv = epv; e.tgt = etgt; e.e = ee; e.f = ef;
        exp_q.push_back(e);
    endtask

`ifdef RAS_CHECKPOINT_EN
    ras_ckpt_t saved;
`endif

    initial begin
        rst_n           = 1'b0;
        bus.instr_vld_i = 1'b0;
        bus.call_i      = 1'b0;
        bus.return_i    = 1'b0;
        bus.pc_i        = '0;
        bus.flush_i     = 1'b0;
`ifdef RAS_CHECKPOINT_EN
        bus.restore_i      = 1'b0;
        bus.restore_ckpt_i = '0;
`endif
        step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // 1: two calls, two returns
        step("t1_call_100", 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        step("t1_call_200", 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
        step("t1_ret_a",    1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 1'b0);
        step("t1_ret_b",    1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
        step("t1_empty",    1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0);

        // 2: underflow
        step("t2_ret_empty", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("t2_still_0",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // 3: overflow and wrap
        step("t3_call_10", 1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("t3_call_20", 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("t3_call_30", 1'b1, 1'b1, 1'b0, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("t3_call_40", 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("t3_call_50", 1'b1, 1'b1, 1'b0, 32'h50, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step("t3_ret_1",   1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h54, 1'b0, 1'b1);
        step("t3_ret_2",   1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
        step("t3_ret_3",   1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h34, 1'b0, 1'b0);
        step("t3_ret_4",   1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h24, 1'b0, 1'b0);
        step("t3_ret_5",   1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0);

        // 4: simultaneous call+return replaces the top
        step("t4_call_100", 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        step("t4_swap_300", 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
        step("t4_ret",      1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h304, 1'b0, 1'b0);
        step("t4_empty",    1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0);

        // 5: flush wins over a concurrent return
        step("t5_call_100", 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("t5_call_200", 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("t5_flush",    1'b1, 1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step("t5_empty",    1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("t5_ret",      1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Swap on an empty stack is a plain push; returns without instr_vld are ignored.
        step("x_swap_empty", 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        step("x_ret_504",    1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h504, 1'b0, 1'b0);
        step("x_call_600",   1'b1, 1'b1, 1'b0, 32'h600, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        step("x_ret_novld",  1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
        step("x_ret_604",    1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h604, 1'b0, 1'b0);
        step("x_empty",      1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0);

`ifdef RAS_CHECKPOINT_EN
        // 6: checkpoint after one call, unwind, then restore
        step("t6_call_100", 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("t6_capture",  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 saved = bus.ckpt_o;
        step("t6_call_200", 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
        step("t6_ret_a",    1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 1'b0);
        step("t6_ret_b",    1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
        step("t6_restore",  1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        bus.restore_i      = 1'b1;
        bus.restore_ckpt_i = saved;
        step("t6_ret_104",  1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
        step("t6_empty",    1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
